// File: rtl/gate_bist.sv
// Built-in self-test sequencer for a 2-input gate: sweeps vectors 00,01,10,11,
// compares the gate response against a 4-bit truth table and reports the result.
module gate_bist #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [3:0]       expected,
  input  logic             dutOut,
  output logic             inA,
  output logic             inB,
  output logic             busy,
  output logic             done,
  output logic             passed,
  output logic [CNT_W-1:0] failCount,
  output logic [1:0]       firstFailIdx,
  output logic             firstFailValid
);

  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(PASSES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  state_t             state, state_next;
  logic [3:0]         exp_reg, exp_next;
  logic [1:0]         idx, idx_next;
  logic [PASS_W-1:0]  pass_cnt, pass_next;
  logic [SET_W-1:0]   settle_cnt, settle_next;
  logic [CNT_W-1:0]   fail_next, fail_bumped;
  logic [1:0]         ffi_next;
  logic               ffv_next;
  logic               passed_next;
  logic               in_a_next, in_b_next;
  logic               mismatch;

  assign busy = (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state          <= IDLE;
      exp_reg        <= '0;
      idx            <= '0;
      pass_cnt       <= '0;
      settle_cnt     <= '0;
      failCount      <= '0;
      firstFailIdx   <= '0;
      firstFailValid <= 1'b0;
      passed         <= 1'b0;
      inA            <= 1'b0;
      inB            <= 1'b0;
    end else begin
      state          <= state_next;
      exp_reg        <= exp_next;
      idx            <= idx_next;
      pass_cnt       <= pass_next;
      settle_cnt     <= settle_next;
      failCount      <= fail_next;
      firstFailIdx   <= ffi_next;
      firstFailValid <= ffv_next;
      passed         <= passed_next;
      inA            <= in_a_next;
      inB            <= in_b_next;
    end
  end

  // The vector drive is registered, so the next vector is chosen here one edge ahead.
  always_comb begin
    state_next  = state;
    exp_next    = exp_reg;
    idx_next    = idx;
    pass_next   = pass_cnt;
    settle_next = settle_cnt;
    fail_next   = failCount;
    ffi_next    = firstFailIdx;
    ffv_next    = firstFailValid;
    passed_next = passed;
    in_a_next   = inA;
    in_b_next   = inB;

    mismatch    = (dutOut != exp_reg[idx]);
    fail_bumped = (mismatch && !(&failCount)) ? failCount + CNT_W'(1) : failCount;

    case (state)
      IDLE: begin
        in_a_next = 1'b0;
        in_b_next = 1'b0;
        if (start) begin
          exp_next    = expected;
          idx_next    = '0;
          pass_next   = '0;
          settle_next = '0;
          fail_next   = '0;
          ffi_next    = '0;
          ffv_next    = 1'b0;
          passed_next = 1'b0;
          state_next  = SETTLE;
        end
      end

      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_next = SAMPLE;
        end else begin
          settle_next = settle_cnt + SET_W'(1);
        end
      end

      SAMPLE: begin
        fail_next   = fail_bumped;
        settle_next = '0;
        if (mismatch && !firstFailValid) begin
          ffi_next = idx;
          ffv_next = 1'b1;
        end
        if (idx != 2'd3) begin
          idx_next   = idx + 2'd1;
          in_a_next  = idx_next[1];
          in_b_next  = idx_next[0];
          state_next = SETTLE;
        end else begin
          idx_next  = '0;
          in_a_next = 1'b0;
          in_b_next = 1'b0;
          if (pass_cnt != PASS_LAST) begin
            pass_next  = pass_cnt + PASS_W'(1);
            state_next = SETTLE;
          end else begin
            passed_next = (fail_bumped == '0);
            state_next  = DONE;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gate_bist.sv
// Scoreboard bench for gate_bist: three instances with different parameters,
// per-cycle vector/busy/done traces and end-of-run results predicted by a gate model.
module tb_gate_bist;

  localparam int NDUT = 3;
  localparam int M_OR = 0, M_AND = 1, M_TIE0 = 2, M_TIE1 = 3;

  typedef struct {
    int   cyc;
    int   dut;
    logic busy;
    logic done;
    logic a;
    logic b;
  } trace_t;

  typedef struct {
    int         dut;
    logic       passed;
    logic [3:0] fc;
    logic [1:0] ffi;
    logic       ffv;
  } result_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start   [NDUT];
  logic [3:0] exp_in  [NDUT];
  int         mode    [NDUT];
  logic       dout    [NDUT];

  logic       a0, b0, busy0, done0, passed0, ffv0;
  logic       a1, b1, busy1, done1, passed1, ffv1;
  logic       a2, b2, busy2, done2, passed2, ffv2;
  logic [3:0] fc0, fc1;
  logic [1:0] fc2;
  logic [1:0] ffi0, ffi1, ffi2;

  logic       obs_a    [NDUT];
  logic       obs_b    [NDUT];
  logic       obs_busy [NDUT];
  logic       obs_done [NDUT];
  logic       obs_pass [NDUT];
  logic [3:0] obs_fc   [NDUT];
  logic [1:0] obs_ffi  [NDUT];
  logic       obs_ffv  [NDUT];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  trace_t  trace_q[$];
  result_t res_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic gate(input int m, input logic a, input logic b);
    case (m)
      M_OR:    return a | b;
      M_AND:   return a & b;
      M_TIE0:  return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int setOf(input int k);
    return 1;
  endfunction

  function automatic int passOf(input int k);
    return (k == 1) ? 3 : (k == 2) ? 2 : 1;
  endfunction

  function automatic int cntwOf(input int k);
    return (k == 2) ? 2 : 4;
  endfunction

  always_comb begin
    dout[0] = gate(mode[0], a0, b0);
    dout[1] = gate(mode[1], a1, b1);
    dout[2] = gate(mode[2], a2, b2);
  end

  always_comb begin
    obs_a[0] = a0; obs_b[0] = b0; obs_busy[0] = busy0; obs_done[0] = done0;
    obs_pass[0] = passed0; obs_fc[0] = fc0; obs_ffi[0] = ffi0; obs_ffv[0] = ffv0;
    obs_a[1] = a1; obs_b[1] = b1; obs_busy[1] = busy1; obs_done[1] = done1;
    obs_pass[1] = passed1; obs_fc[1] = fc1; obs_ffi[1] = ffi1; obs_ffv[1] = ffv1;
    obs_a[2] = a2; obs_b[2] = b2; obs_busy[2] = busy2; obs_done[2] = done2;
    obs_pass[2] = passed2; obs_fc[2] = {2'b00, fc2}; obs_ffi[2] = ffi2; obs_ffv[2] = ffv2;
  end

  gate_bist #(.SETTLE_CYCLES(1), .PASSES(1), .CNT_W(4)) dut0 (
    .clk(clk), .resetN(reset_n), .start(start[0]), .expected(exp_in[0]), .dutOut(dout[0]),
    .inA(a0), .inB(b0), .busy(busy0), .done(done0), .passed(passed0),
    .failCount(fc0), .firstFailIdx(ffi0), .firstFailValid(ffv0)
  );

  gate_bist #(.SETTLE_CYCLES(1), .PASSES(3), .CNT_W(4)) dut1 (
    .clk(clk), .resetN(reset_n), .start(start[1]), .expected(exp_in[1]), .dutOut(dout[1]),
    .inA(a1), .inB(b1), .busy(busy1), .done(done1), .passed(passed1),
    .failCount(fc1), .firstFailIdx(ffi1), .firstFailValid(ffv1)
  );

  gate_bist #(.SETTLE_CYCLES(1), .PASSES(2), .CNT_W(2)) dut2 (
    .clk(clk), .resetN(reset_n), .start(start[2]), .expected(exp_in[2]), .dutOut(dout[2]),
    .inA(a2), .inB(b2), .busy(busy2), .done(done2), .passed(passed2),
    .failCount(fc2), .firstFailIdx(ffi2), .firstFailValid(ffv2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Predict the per-cycle trace and the final result of one run accepted in cycle t0.
  task automatic pushRun(input int k, input int t0, input logic [3:0] e, input int m);
    int      s, p, l, fails, first, maxc;
    trace_t  t;
    result_t r;
    logic [1:0] v;
    s = setOf(k);
    p = passOf(k);
    l = 4 * p * (s + 1);
    for (int j = 1; j <= l + 2; j++) begin
      t.cyc = t0 + j;
      t.dut = k;
      v = 2'((j - 1) / (s + 1));
      if (j <= l) begin
        t.busy = 1'b1; t.done = 1'b0; t.a = v[1]; t.b = v[0];
      end else begin
        t.busy = 1'b0; t.done = (j == l + 1); t.a = 1'b0; t.b = 1'b0;
      end
      trace_q.push_back(t);
    end
    fails = 0;
    first = -1;
    for (int pp = 0; pp < p; pp++) begin
      for (int vv = 0; vv < 4; vv++) begin
        v = 2'(vv);
        if (gate(m, v[1], v[0]) != e[vv]) begin
          fails++;
          if (first < 0) first = vv;
        end
      end
    end
    maxc     = (1 << cntwOf(k)) - 1;
    r.dut    = k;
    r.fc     = 4'((fails > maxc) ? maxc : fails);
    r.ffi    = (first < 0) ? 2'd0 : 2'(first);
    r.ffv    = (first >= 0);
    r.passed = (fails == 0);
    res_q.push_back(r);
  endtask

  // Called at a negedge while the DUT is idle; pulses start for one cycle.
  task automatic applyStimulus(input int k, input logic [3:0] e, input int m,
                               input bit track, output int t0);
    mode[k]   = m;
    exp_in[k] = e;
    start[k]  = 1'b1;
    t0        = cyc;
    if (track) pushRun(k, t0, e, m);
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    while ((trace_q.size() > 0 || res_q.size() > 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("queue_drain", trace_q.size() + res_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic checkAllZero(input int k, input string tag);
    checkOutput($sformatf("%s_d%0d_inA", tag, k), obs_a[k], 0);
    checkOutput($sformatf("%s_d%0d_inB", tag, k), obs_b[k], 0);
    checkOutput($sformatf("%s_d%0d_busy", tag, k), obs_busy[k], 0);
    checkOutput($sformatf("%s_d%0d_done", tag, k), obs_done[k], 0);
    checkOutput($sformatf("%s_d%0d_passed", tag, k), obs_pass[k], 0);
    checkOutput($sformatf("%s_d%0d_failCount", tag, k), obs_fc[k], 0);
    checkOutput($sformatf("%s_d%0d_firstFailIdx", tag, k), obs_ffi[k], 0);
    checkOutput($sformatf("%s_d%0d_firstFailValid", tag, k), obs_ffv[k], 0);
  endtask

  // Scoreboard monitor: traces popped on their cycle, results popped on done.
  always @(negedge clk) begin : monitor
    trace_t  t;
    result_t r;
    while (trace_q.size() > 0 && trace_q[0].cyc <= cyc) begin
      t = trace_q.pop_front();
      checkOutput($sformatf("d%0d_busy_c%0d", t.dut, t.cyc), obs_busy[t.dut], t.busy);
      checkOutput($sformatf("d%0d_done_c%0d", t.dut, t.cyc), obs_done[t.dut], t.done);
      checkOutput($sformatf("d%0d_inA_c%0d", t.dut, t.cyc), obs_a[t.dut], t.a);
      checkOutput($sformatf("d%0d_inB_c%0d", t.dut, t.cyc), obs_b[t.dut], t.b);
    end
    for (int k = 0; k < NDUT; k++) begin
      if (obs_busy[k] === 1'b1 && $isunknown(dout[k]))
        checkOutput($sformatf("d%0d_dutOut_known", k), $isunknown(dout[k]), 0);
      if (obs_done[k] === 1'b1) begin
        if (res_q.size() == 0) begin
          checkOutput($sformatf("d%0d_done_unexpected", k), obs_done[k], 0);
        end else begin
          r = res_q.pop_front();
          checkOutput($sformatf("d%0d_done_owner", k), k, r.dut);
          checkOutput($sformatf("d%0d_passed", k), obs_pass[k], r.passed);
          checkOutput($sformatf("d%0d_failCount", k), obs_fc[k], r.fc);
          checkOutput($sformatf("d%0d_firstFailIdx", k), obs_ffi[k], r.ffi);
          checkOutput($sformatf("d%0d_firstFailValid", k), obs_ffv[k], r.ffv);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] simulation did not terminate");
  end

  initial begin : stimulus
    int t0;
    reset_n = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      start[k]  = 1'b0;
      exp_in[k] = 4'b0000;
      mode[k]   = M_OR;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) checkAllZero(k, "reset");
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] correct Or gate, Or truth table");
    applyStimulus(0, 4'b1110, M_OR, 1'b1, t0);
    waitIdle(100);

    $display("[TB] And gate against Or truth table");
    applyStimulus(0, 4'b1110, M_AND, 1'b1, t0);
    waitIdle(100);
    checkOutput("and_hold_failCount", fc0, 2);
    checkOutput("and_hold_firstFailIdx", ffi0, 1);
    checkOutput("and_hold_firstFailValid", ffv0, 1);

    $display("[TB] three passes, output tied low");
    applyStimulus(1, 4'b1110, M_TIE0, 1'b1, t0);
    waitIdle(200);

    $display("[TB] narrow counter saturation, output tied high");
    applyStimulus(2, 4'b0000, M_TIE1, 1'b1, t0);
    waitIdle(200);

    $display("[TB] start pulsed mid-run");
    applyStimulus(0, 4'b1110, M_OR, 1'b1, t0);
    while (cyc < t0 + 3) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    waitIdle(100);

    $display("[TB] start held across two runs");
    mode[0]   = M_AND;
    exp_in[0] = 4'b1110;
    start[0]  = 1'b1;
    t0        = cyc;
    pushRun(0, t0, 4'b1110, M_AND);
    while (cyc < t0 + 9) @(negedge clk);
    mode[0] = M_OR;
    pushRun(0, t0 + 10, 4'b1110, M_OR);
    while (cyc < t0 + 11) @(negedge clk);
    start[0] = 1'b0;
    waitIdle(100);

    $display("[TB] reset mid-run");
    applyStimulus(0, 4'b1111, M_TIE0, 1'b0, t0);
    while (cyc < t0 + 4) @(negedge clk);
    checkOutput("midrun_busy", busy0, 1);
    checkOutput("midrun_failCount", fc0, 1);
    checkOutput("midrun_inB", b0, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkAllZero(0, "after_reset");
    repeat (12) @(negedge clk);
    checkOutput("after_reset_idle_busy", busy0, 0);
    applyStimulus(0, 4'b1110, M_OR, 1'b1, t0);
    waitIdle(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
